bus_bridge_periph: RTL
======================

Name: bus_bridge_periph

Overview:
Responder side of the CPU data bus: it decodes each CPU bus access and either passes it to the data RAM or serves it from the memory-mapped peripheral registers. Peripherals are a LED register, a 2-flop synchronised switch/button input, a free-running 32-bit timer, and an 8-digit multiplexed seven-segment display driver. It sits between the CPU's Bus_* port and the board I/O and DRAM.

Parameters:
SCAN_DIV, 20000, cpu_clk cycles each display digit stays lit (must be >= 2)
LED_W, 24, width of LED register and switch input

Ports:
cpu_clk  in  1  system clock, rising edge
cpu_rst  in  1  asynchronous, active-high reset
Bus_addr  in  32  CPU byte address, word-aligned
Bus_we  in  1  CPU write strobe for the current cycle
Bus_wdata  in  32  CPU write data
Bus_rdata  out  32  read data returned to CPU, same cycle
dram_addr  out  14  DRAM word address
dram_we  out  1  DRAM write enable
dram_wdata  out  32  DRAM write data
dram_rdata  in  32  DRAM read data, combinational
sw  in  LED_W  board switches, asynchronous
button  in  5  board buttons, asynchronous
led  out  LED_W  LED drive, active-high
dig_en  out  8  digit enables, active-low, one-hot
dig_seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low

Behaviour:
- Peripheral window: Bus_addr[31:12] == 20'hFFFFF. Any other address is DRAM.
- DRAM path:
  - dram_addr = Bus_addr[15:2]
  - dram_wdata = Bus_wdata
  - dram_we = Bus_we & ~window
  - Bus_rdata = dram_rdata
- Window offsets (Bus_addr[11:0]):
  - 0x000 TUBE: R/W, 32 bits, 8 nibbles
  - 0x020 TIMER: R/W
  - 0x060 LED: R/W, low LED_W bits; upper bits read 0
  - 0x070 SW: RO, zero-extended
  - 0x078 BTN: RO, {27'b0, button}
  - Other offsets in the window read 32'h0. Writes to them are ignored. Writes to SW/BTN are ignored.
- Reads are combinational from current register state, with zero latency, because the CPU samples Bus_rdata in its MEM stage.
- Writes take effect on the cpu_clk rising edge where Bus_we=1. A read in the following cycle returns the new value.
- SW and BTN pass through two flops. The value read reflects pin state 2 edges earlier.
- TIMER:
  - Increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0.
  - A write loads Bus_wdata; that cycle's increment is suppressed.
  - It counts from the loaded value on the next edge (write X -> reads X, then X+1, ...).
- Display scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - dig_idx (3 bits) increments on each wrap; 7 -> 0.
  - dig_en = ~(8'b1 << dig_idx).
  - dig_seg = hex decode of TUBE[4*dig_idx+3 : 4*dig_idx], DP always 1 (off).
  - Decode values (0-F): C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - dig_en and dig_seg are combinational from registered state. A TUBE write is visible on dig_seg the cycle after the write edge.
- Reset (async, any time including mid-scan or mid-write):
  - led=0, TUBE=0, TIMER=0, sync flops=0, scan_cnt=0, dig_idx=0
  - Hence dig_en=8'hFE, dig_seg=8'hC0, Bus_rdata for any window read = 0.
  - A write coincident with reset assertion is lost.
- Simultaneous events: the DRAM path and peripheral registers are never both written, because the decode is exclusive.

Test Plan:
- Reset mid-run with SCAN_DIV=4 -> led=0, dig_en=8'hFE, dig_seg=8'hC0, TIMER read at 0xFFFFF020 = 0 then 1 the following cycle.
- Write 0xFFFFF060 <= 32'hFFABCDEF (LED_W=24) -> led=24'hABCDEF next cycle; read returns 32'h00ABCDEF; dram_we stays 0.
- Drive sw=24'h00A5A5 at edge N -> read 0xFFFFF070 returns 0 before edge N+2 and 32'h0000A5A5 from edge N+2.
- Write TIMER <= 32'hFFFFFFFE -> consecutive reads FFFFFFFE, FFFFFFFF, 00000000.
- SCAN_DIV=4, TUBE <= 32'h8765432F -> dig_en cycles FE, FD, FB, ... 7F, FE, each held 4 cycles; dig_seg = 8E, A4, B0, 99, 92, 82, F8, 80 in that order.
- Bus_addr=32'h00001234, Bus_we=1, wdata=5 -> dram_addr=14'h048D, dram_we=1, dram_wdata=5; a read of 0xFFFFF040 returns 0.

Source files
------------

// File: rtl/bus_bridge_periph.sv
// bus_bridge_periph: CPU data-bus responder splitting accesses between DRAM and memory-mapped peripherals
module bus_bridge_periph #(
  parameter int SCAN_DIV = 20000,
  parameter int LED_W    = 24
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic [31:0]      Bus_addr,
  input  logic             Bus_we,
  input  logic [31:0]      Bus_wdata,
  output logic [31:0]      Bus_rdata,
  output logic [13:0]      dram_addr,
  output logic             dram_we,
  output logic [31:0]      dram_wdata,
  input  logic [31:0]      dram_rdata,
  input  logic [LED_W-1:0] sw,
  input  logic [4:0]       button,
  output logic [LED_W-1:0] led,
  output logic [7:0]       dig_en,
  output logic [7:0]       dig_seg
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [LED_W-1:0] r_led, r_sw1, r_sw2;
  logic [4:0]       r_btn1, r_btn2;
  logic [31:0]      r_tube, r_timer;
  logic [CW-1:0]    r_scan_cnt;
  logic [2:0]       r_dig_idx;
  logic             w_win, w_wr, w_unused;
  logic [11:0]      w_off;
  logic [3:0]       w_nib;
  assign w_win      = Bus_addr[31:12] == 20'hFFFFF;
  assign w_off      = Bus_addr[11:0];
  assign w_wr       = Bus_we & w_win;
  assign w_unused   = &{1'b0, Bus_addr[1:0]};
  assign dram_addr  = Bus_addr[15:2];
  assign dram_wdata = Bus_wdata;
  assign dram_we    = Bus_we & ~w_win;
  assign led        = r_led;
  assign w_nib      = r_tube[{r_dig_idx, 2'b00} +: 4];
  assign dig_en     = ~(8'b1 << r_dig_idx);
  assign dig_seg    = SEG[w_nib];
  // zero-latency read mux: DRAM outside the window, register file inside it
  always_comb begin
    Bus_rdata = !w_win           ? dram_rdata :
                w_off == 12'h000 ? r_tube :
                w_off == 12'h020 ? r_timer :
                w_off == 12'h060 ? 32'(r_led) :
                w_off == 12'h070 ? 32'(r_sw2) :
                w_off == 12'h078 ? 32'(r_btn2) : 32'h0;
  end
  // writable peripheral registers; the timer free-runs unless loaded
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_led   <= '0;
      r_tube  <= '0;
      r_timer <= '0;
    end else begin
      if (w_wr && w_off == 12'h060) r_led <= Bus_wdata[LED_W-1:0];
      if (w_wr && w_off == 12'h000) r_tube <= Bus_wdata;
      r_timer <= (w_wr && w_off == 12'h020) ? Bus_wdata : r_timer + 32'd1;
    end
  end
  // two-flop synchronisers for the asynchronous switch and button pins
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_sw1  <= '0;
      r_sw2  <= '0;
      r_btn1 <= '0;
      r_btn2 <= '0;
    end else begin
      r_sw1  <= sw;
      r_sw2  <= r_sw1;
      r_btn1 <= button;
      r_btn2 <= r_btn1;
    end
  end
  // display scan: each digit is lit for SCAN_DIV cycles, then the next one
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
    end else begin
      r_scan_cnt <= (r_scan_cnt == CW'(SCAN_DIV - 1)) ? '0 : r_scan_cnt + 1'b1;
      if (r_scan_cnt == CW'(SCAN_DIV - 1)) r_dig_idx <= r_dig_idx + 3'd1;
    end
  end
endmodule
